// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC output-side blocks: data width, queue entry
// layout and the hex-to-seven-segment lookup.
// No ports; imported by lmc_sync_edge and lmc_output_queue.
package lmc_pkg;

  localparam int LMC_DATA_WIDTH = 4;

  // One captured CPU output: flags sit above the value, matching rd_data.
  typedef struct packed {
    logic                      pz;
    logic                      z;
    logic [LMC_DATA_WIDTH-1:0] data;
  } lmc_out_entry_t;

  // Active-high segments, bit order {g,f,e,d,c,b,a}; index = hex digit.
  localparam logic [15:0][6:0] LMC_SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/lmc_sync_edge.sv
// Purpose : 2-FF synchronizer plus delay flop giving a one-cycle pulse on the
//           synchronized rising edge of an asynchronous level.
// Latency : input rise before edge k -> o_rise high between edges k+1 and k+2.
// Backpressure: none; pulses are not held.
// Ports   : i_clk, i_rst_n (async active-low), i_async (async level),
//           o_rise (one-cycle rising-edge pulse).
module lmc_sync_edge
  import lmc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_d;
  logic [1:0] r_settle;
  logic       r_armed;

  // The flops come out of reset at 0, so a level that is already high at
  // reset release looks like a fresh edge. Edges are only honoured once the
  // synchronized level has been seen low after the chain has settled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_d      <= 1'b0;
      r_settle <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_s1     <= i_async;
      r_s2     <= r_s1;
      r_d      <= r_s2;
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && !r_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_rise = r_s2 & ~r_d & r_armed;

endmodule

// File: rtl/lmc_output_queue.sv
// Purpose : captures each CPU output (value + Z/PZ flags) on the synchronized
//           rising edge of out_strobe into a FIFO drained by valid/ready.
// Latency : strobe rise before edge k -> entry pushed at edge k+2.
// Backpressure: push while full without a pop is dropped and sets sticky
//           overflow; push+pop on one edge is always accepted.
// Ports   : timer555 clock, reset_n async active-low; out_strobe/out_data/
//           z_flag/pz_flag capture side; clear sync flush; rd_valid/rd_ready/
//           rd_data read side; count/full/empty/overflow status.
// Option  : LMC_OUTQ_SEG7_EN adds the registered seg7 head-digit output.
module lmc_output_queue
  import lmc_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = LMC_DATA_WIDTH
) (
  input  logic                     timer555,
  input  logic                     reset_n,
  input  logic                     out_strobe,
  input  logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     z_flag,
  input  logic                     pz_flag,
  input  logic                     clear,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH+1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef LMC_OUTQ_SEG7_EN
  ,
  output logic [6:0]               seg7
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [EW-1:0] r_head;

  logic          w_capture;
  logic [EW-1:0] w_entry;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_remain;
  logic [EW-1:0] w_head_nxt;

  lmc_sync_edge u_sync (
    .i_clk   (timer555),
    .i_rst_n (reset_n),
    .i_async (out_strobe),
    .o_rise  (w_capture)
  );

  assign w_entry     = {pz_flag, z_flag, out_data};
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = (r_count != '0) && rd_ready;
  assign w_push      = w_capture && (!w_full || w_pop);
  assign w_drop      = w_capture && w_full && !w_pop;
  assign w_rptr_nxt  = r_rptr + AW'(w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // Entries still in the array after this edge's pop, not counting the push.
  assign w_remain    = r_count - CW'(w_pop);

  // The head register holds its value when the queue goes empty. When the
  // only surviving entry is the one being pushed, it bypasses the array.
  always_comb begin
    w_head_nxt = r_head;
    if (w_remain != '0) begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end else if (w_push) begin
      w_head_nxt = w_entry;
    end
  end

  always_ff @(posedge timer555) begin
    if (w_push && !clear) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_head  <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign rd_valid = (r_count != '0);
  assign rd_data  = r_head;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = (r_count == '0);
  assign overflow = r_ovf;

`ifdef LMC_OUTQ_SEG7_EN
  logic [6:0] r_seg7;

  always_ff @(posedge timer555 or negedge reset_n) begin
    if (!reset_n) begin
      r_seg7 <= 7'b0000000;
    end else begin
      r_seg7 <= rd_valid ? LMC_SEG7_LUT[4'(r_head[DATA_WIDTH-1:0])] : 7'b0000000;
    end
  end

  assign seg7 = r_seg7;
`endif

endmodule

// File: tb/tb_lmc_output_queue.sv
module tb_lmc_output_queue;
  import lmc_pkg::*;

  logic       timer555 = 1'b0;
  logic       reset_n;
  logic       out_strobe;
  logic [3:0] out_data;
  logic       z_flag;
  logic       pz_flag;
  logic       clear;
  logic       rd_valid;
  logic       rd_ready;
  logic [5:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
`ifdef LMC_OUTQ_SEG7_EN
  logic [6:0] seg7;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 timer555 = ~timer555;

  lmc_output_queue #(.DEPTH(8), .DATA_WIDTH(4)) dut (
    .timer555   (timer555),
    .reset_n    (reset_n),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .z_flag     (z_flag),
    .pz_flag    (pz_flag),
    .clear      (clear),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
`ifdef LMC_OUTQ_SEG7_EN
    ,
    .seg7       (seg7)
`endif
  );

  typedef struct {
    logic [3:0] data;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t fill_tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Flags model a signed 4-bit accumulator: Z when zero, PZ when bit 3 clear.
  function automatic logic [5:0] exp_entry(input logic [3:0] v);
    lmc_out_entry_t e;
    e.pz   = ~v[3];
    e.z    = (v == 4'h0);
    e.data = v;
    return e;
  endfunction

  task automatic set_val(input logic [3:0] v);
    out_data = v;
    z_flag   = (v == 4'h0);
    pz_flag  = ~v[3];
  endtask

  // Full strobe: high 3 cycles (push lands on the third edge), low 2 cycles.
  task automatic strobe_val(input logic [3:0] v);
    set_val(v);
    out_strobe = 1'b1;
    repeat (3) @(negedge timer555);
    out_strobe = 1'b0;
    repeat (2) @(negedge timer555);
  endtask

  task automatic drain(input int n, input logic [3:0] first);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, exp_entry(first + 4'(i)));
      @(negedge timer555);
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // 0..8 pushed with rd_ready low; the ninth is dropped.
    fill_tbl[0] = '{4'h0, 4'd1, 1'b0, 1'b0};
    fill_tbl[1] = '{4'h1, 4'd2, 1'b0, 1'b0};
    fill_tbl[2] = '{4'h2, 4'd3, 1'b0, 1'b0};
    fill_tbl[3] = '{4'h3, 4'd4, 1'b0, 1'b0};
    fill_tbl[4] = '{4'h4, 4'd5, 1'b0, 1'b0};
    fill_tbl[5] = '{4'h5, 4'd6, 1'b0, 1'b0};
    fill_tbl[6] = '{4'h6, 4'd7, 1'b0, 1'b0};
    fill_tbl[7] = '{4'h7, 4'd8, 1'b1, 1'b0};
    fill_tbl[8] = '{4'h8, 4'd8, 1'b1, 1'b1};

    reset_n    = 1'b0;
    out_strobe = 1'b0;
    out_data   = 4'h0;
    z_flag     = 1'b0;
    pz_flag    = 1'b0;
    clear      = 1'b0;
    rd_ready   = 1'b0;
    repeat (2) @(negedge timer555);

    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", overflow, 0);
`ifdef LMC_OUTQ_SEG7_EN
    chk("rst_seg7", seg7, 0);
`endif
    reset_n = 1'b1;
    repeat (5) @(negedge timer555);

    // Single capture: rd_valid appears on the third edge after the rise.
    set_val(4'h5);
    out_strobe = 1'b1;
    @(negedge timer555);
    chk("lat_edge1", rd_valid, 0);
    @(negedge timer555);
    chk("lat_edge2", rd_valid, 0);
    @(negedge timer555);
    chk("lat_edge3", rd_valid, 1);
    chk("single_data", rd_data, 6'b10_0101);
    chk("single_count", count, 1);
    out_strobe = 1'b0;
    @(negedge timer555);
`ifdef LMC_OUTQ_SEG7_EN
    chk("single_seg7", seg7, 7'h6D);
`endif
    @(negedge timer555);
    drain(1, 4'h5);
    chk("single_empty", empty, 1);

    // Long strobe gives exactly one entry.
    set_val(4'h3);
    out_strobe = 1'b1;
    repeat (20) @(negedge timer555);
    chk("long_count", count, 1);
    out_strobe = 1'b0;
    repeat (4) @(negedge timer555);
    chk("long_count_after", count, 1);
    drain(1, 4'h3);

    // Table: fill to full and overflow.
    for (int i = 0; i < 9; i++) begin
      strobe_val(fill_tbl[i].data);
      chk("fill_count", count, 32'(fill_tbl[i].exp_count));
      chk("fill_full", full, 32'(fill_tbl[i].exp_full));
      chk("fill_ovf", overflow, 32'(fill_tbl[i].exp_ovf));
    end
    drain(8, 4'h0);
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    clear = 1'b1;
    @(negedge timer555);
    clear = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_count", count, 0);

    // Full queue: capture and pop land on the same edge.
    for (int i = 1; i <= 8; i++) strobe_val(4'(i));
    chk("pp_full_before", full, 1);
    set_val(4'h9);
    out_strobe = 1'b1;
    repeat (2) @(negedge timer555);
    rd_ready = 1'b1;
    @(negedge timer555);
    rd_ready = 1'b0;
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    out_strobe = 1'b0;
    repeat (2) @(negedge timer555);
    drain(8, 4'h2);
    chk("pp_empty", empty, 1);

    // 12 capture/pop pairs walk the pointers round the ring.
    for (int i = 0; i < 12; i++) begin
      logic [3:0] v;
      v = 4'((i * 5 + 3) % 16);
      strobe_val(v);
      chk("wrap_count", count, 1);
      drain(1, v);
    end
    chk("wrap_empty", empty, 1);

    // clear on the same edge as a capture with three entries queued.
    strobe_val(4'hA);
    strobe_val(4'hB);
    strobe_val(4'hC);
    chk("cc_count_before", count, 3);
    set_val(4'hD);
    out_strobe = 1'b1;
    repeat (2) @(negedge timer555);
    clear = 1'b1;
    @(negedge timer555);
    clear = 1'b0;
    chk("cc_count", count, 0);
    chk("cc_empty", empty, 1);
    chk("cc_ovf", overflow, 0);
    chk("cc_valid", rd_valid, 0);
    @(negedge timer555);
`ifdef LMC_OUTQ_SEG7_EN
    chk("cc_seg7", seg7, 0);
`endif
    chk("cc_count_later", count, 0);
    out_strobe = 1'b0;
    repeat (2) @(negedge timer555);

    // Async reset mid-operation, strobe held high through reset release.
    strobe_val(4'h1);
    strobe_val(4'h2);
    chk("ar_count_before", count, 2);
    out_strobe = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", rd_valid, 0);
    chk("ar_empty", empty, 1);
    repeat (2) @(negedge timer555);
    reset_n = 1'b1;
    repeat (6) @(negedge timer555);
    chk("ar_no_capture", count, 0);
    out_strobe = 1'b0;
    repeat (4) @(negedge timer555);
    strobe_val(4'h7);
    chk("ar_recapture_count", count, 1);
    chk("ar_recapture_data", rd_data, exp_entry(4'h7));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
